// File: rtl/axi_ifetch_rom.sv
// axi_ifetch_rom: AXI4 read-only program memory for the instruction-fetch port.
// Reads are served from a word array that is preloaded through the load port.
// Writes are drained and answered with SLVERR.
// Optional: define AXI_IFETCH_ROM_WRAP_EN to support WRAP bursts
// (arlen of 1, 3, 7 or 15). Without it, WRAP bursts behave as INCR.
module axi_ifetch_rom #(
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          ID_W      = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     axi_arvalid_i,
   input  logic [31:0]              axi_araddr_i,
   input  logic [ID_W-1:0]          axi_arid_i,
   input  logic [7:0]               axi_arlen_i,
   input  logic [1:0]               axi_arburst_i,
   output logic                     axi_arready_o,
   output logic                     axi_rvalid_o,
   output logic [31:0]              axi_rdata_o,
   output logic [1:0]               axi_rresp_o,
   output logic [ID_W-1:0]          axi_rid_o,
   output logic                     axi_rlast_o,
   input  logic                     axi_rready_i,
   input  logic                     axi_awvalid_i,
   input  logic [ID_W-1:0]          axi_awid_i,
   output logic                     axi_awready_o,
   input  logic                     axi_wvalid_i,
   input  logic                     axi_wlast_i,
   output logic                     axi_wready_o,
   output logic                     axi_bvalid_o,
   output logic [1:0]               axi_bresp_o,
   output logic [ID_W-1:0]          axi_bid_o,
   input  logic                     axi_bready_i,
   input  logic                     load_we_i,
   input  logic [$clog2(DEPTH)-1:0] load_addr_i,
   input  logic [31:0]              load_data_i
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {IDLE, RD, WDATA, WRESP} state_t;

   state_t state_reg, state_next;

   logic [31:0] mem [DEPTH];

   // Burst context latched at the address handshake
   logic [31:0]     start_reg;
   logic [7:0]      len_reg;
   logic [1:0]      burst_reg;
   logic [ID_W-1:0] id_reg;
   logic [7:0]      beat_reg;

   // Registered read channel and write response
   logic            rvalid_reg;
   logic            rlast_reg;
   logic [31:0]     rdata_reg;
   logic [1:0]      rresp_reg;
   logic [ID_W-1:0] rid_reg;
   logic [1:0]      bresp_reg;
   logic [ID_W-1:0] bid_reg;

   logic            ar_hs, aw_hs, r_hs, rd_adv, load_beat, w_done;
   logic [31:0]     sel_start;
   logic [7:0]      sel_len, sel_beat;
   logic [1:0]      sel_burst;
   logic [ID_W-1:0] sel_id;
   logic [31:0]     incr_addr, beat_addr;
   logic            beat_slverr, in_range;
   logic [29:0]     offset_word;
   logic [AW-1:0]   rd_idx;

   assign ar_hs  = (state_reg == IDLE) && axi_arvalid_i;
   assign aw_hs  = (state_reg == IDLE) && !axi_arvalid_i && axi_awvalid_i;
   assign r_hs   = rvalid_reg && axi_rready_i;
   assign rd_adv = (state_reg == RD) && r_hs && !rlast_reg;
   assign w_done = (state_reg == WDATA) && axi_wvalid_i && axi_wlast_i;
   // A new beat is loaded either by the AR handshake (beat 0) or by consuming a non-last beat
   assign load_beat = ar_hs || rd_adv;

   // Pick the burst context and beat number of the beat about to be loaded
   always_comb begin
      sel_start = start_reg;
      sel_len   = len_reg;
      sel_burst = burst_reg;
      sel_id    = id_reg;
      sel_beat  = beat_reg + 8'd1;
      if (ar_hs) begin
         sel_start = axi_araddr_i;
         sel_len   = axi_arlen_i;
         sel_burst = axi_arburst_i;
         sel_id    = axi_arid_i;
         sel_beat  = 8'd0;
      end
   end

   // Beat address from start address, burst type and beat number
   always_comb begin
      incr_addr   = sel_start + {22'd0, sel_beat, 2'b00};
      beat_addr   = incr_addr;
      beat_slverr = 1'b0;
      case (sel_burst)
         2'b00: beat_addr = sel_start;
         2'b01: beat_addr = incr_addr;
         2'b10: begin
`ifdef AXI_IFETCH_ROM_WRAP_EN
            // span-1 = 4*(len+1)-1 = {len, 2'b11}
            if (sel_len == 8'd1 || sel_len == 8'd3 || sel_len == 8'd7 || sel_len == 8'd15)
               beat_addr = (sel_start & ~{22'd0, sel_len, 2'b11}) | (incr_addr & {22'd0, sel_len, 2'b11});
            else
               beat_slverr = 1'b1;
`else
            beat_addr = incr_addr;
`endif
         end
         default: beat_slverr = 1'b1;
      endcase
   end

   // Word offset from the base; in range when above the base and below DEPTH words
   assign offset_word = beat_addr[31:2] - BASE_ADDR[31:2];
   assign in_range    = (beat_addr >= BASE_ADDR) && (offset_word[29:AW] == '0);
   assign rd_idx      = offset_word[AW-1:0];

   // Preload port writes the array in any state; the array is never reset
   always_ff @(posedge clk_i) begin
      if (load_we_i)
         mem[load_addr_i] <= load_data_i;
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state and handshake-ready outputs
   always_comb begin
      state_next    = state_reg;
      axi_arready_o = 1'b0;
      axi_awready_o = 1'b0;
      axi_wready_o  = 1'b0;
      axi_bvalid_o  = 1'b0;
      case (state_reg)
         IDLE: begin
            axi_arready_o = 1'b1;
            axi_awready_o = !axi_arvalid_i;
            if (axi_arvalid_i)
               state_next = RD;
            else if (axi_awvalid_i)
               state_next = WDATA;
         end
         RD: begin
            if (r_hs && rlast_reg)
               state_next = IDLE;
         end
         WDATA: begin
            axi_wready_o = 1'b1;
            if (axi_wvalid_i && axi_wlast_i)
               state_next = WRESP;
         end
         WRESP: begin
            axi_bvalid_o = 1'b1;
            if (axi_bready_i)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Burst context, registered read beat (array read feeds rdata directly) and write response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         start_reg  <= '0;
         len_reg    <= '0;
         burst_reg  <= '0;
         id_reg     <= '0;
         beat_reg   <= '0;
         rvalid_reg <= 1'b0;
         rlast_reg  <= 1'b0;
         rdata_reg  <= '0;
         rresp_reg  <= '0;
         rid_reg    <= '0;
         bresp_reg  <= '0;
         bid_reg    <= '0;
      end else begin
         if (ar_hs) begin
            start_reg <= axi_araddr_i;
            len_reg   <= axi_arlen_i;
            burst_reg <= axi_arburst_i;
            id_reg    <= axi_arid_i;
         end else if (aw_hs) begin
            id_reg <= axi_awid_i;
         end
         if (load_beat) begin
            beat_reg   <= sel_beat;
            rvalid_reg <= 1'b1;
            rlast_reg  <= (sel_beat == sel_len);
            rid_reg    <= sel_id;
            if (beat_slverr) begin
               rresp_reg <= RESP_SLVERR;
               rdata_reg <= '0;
            end else if (!in_range) begin
               rresp_reg <= RESP_DECERR;
               rdata_reg <= '0;
            end else begin
               rresp_reg <= RESP_OKAY;
               rdata_reg <= mem[rd_idx];
            end
         end else if (r_hs) begin
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
         end
         if (w_done) begin
            bresp_reg <= RESP_SLVERR;
            bid_reg   <= id_reg;
         end
      end
   end

   assign axi_rvalid_o = rvalid_reg;
   assign axi_rlast_o  = rlast_reg;
   assign axi_rdata_o  = rdata_reg;
   assign axi_rresp_o  = rresp_reg;
   assign axi_rid_o    = rid_reg;
   assign axi_bresp_o  = bresp_reg;
   assign axi_bid_o    = bid_reg;

endmodule

// File: tb/tb_axi_ifetch_rom.sv
// Testbench for axi_ifetch_rom: directed scenarios plus randomized bursts,
// checked against a word-array reference model of the read/write rules.
module tb_axi_ifetch_rom;

   localparam int          DEPTH = 64;
   localparam int          AW    = $clog2(DEPTH);
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          ID_W  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            arvalid;
   logic [31:0]     araddr;
   logic [ID_W-1:0] arid;
   logic [7:0]      arlen;
   logic [1:0]      arburst;
   logic            arready;
   logic            rvalid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic [ID_W-1:0] rid;
   logic            rlast;
   logic            rready;
   logic            awvalid;
   logic [ID_W-1:0] awid;
   logic            awready;
   logic            wvalid;
   logic            wlast;
   logic            wready;
   logic            bvalid;
   logic [1:0]      bresp;
   logic [ID_W-1:0] bid;
   logic            bready;
   logic            load_we;
   logic [AW-1:0]   load_addr;
   logic [31:0]     load_data;

   logic [31:0] ref_mem [DEPTH];
   int checks = 0;
   int passed = 0;

   axi_ifetch_rom #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ID_W(ID_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .axi_arvalid_i(arvalid), .axi_araddr_i(araddr), .axi_arid_i(arid),
      .axi_arlen_i(arlen), .axi_arburst_i(arburst), .axi_arready_o(arready),
      .axi_rvalid_o(rvalid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
      .axi_rid_o(rid), .axi_rlast_o(rlast), .axi_rready_i(rready),
      .axi_awvalid_i(awvalid), .axi_awid_i(awid), .axi_awready_o(awready),
      .axi_wvalid_i(wvalid), .axi_wlast_i(wlast), .axi_wready_o(wready),
      .axi_bvalid_o(bvalid), .axi_bresp_o(bresp), .axi_bid_o(bid),
      .axi_bready_i(bready),
      .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference: {resp, data} for a given beat, straight from the address rules
   function automatic logic [33:0] exp_beat(input logic [31:0] start, input int len,
                                            input logic [1:0] burst, input int beat);
      logic [31:0] a;
      logic [31:0] span;
      bit          slverr;
      slverr = 0;
      span   = 32'(4 * (len + 1));
      a      = start + 32'(4 * beat);
      case (burst)
         2'b00: a = start;
         2'b01: a = start + 32'(4 * beat);
         2'b10: begin
`ifdef AXI_IFETCH_ROM_WRAP_EN
            if (len == 1 || len == 3 || len == 7 || len == 15)
               a = (start & ~(span - 1)) | ((start + 32'(4 * beat)) & (span - 1));
            else
               slverr = 1;
`else
            a = start + 32'(4 * beat);
`endif
         end
         default: slverr = 1;
      endcase
      if (slverr)
         return {2'b10, 32'd0};
      if (longint'(a) < longint'(BASE) || longint'(a) >= longint'(BASE) + 4 * DEPTH)
         return {2'b11, 32'd0};
      return {2'b00, ref_mem[(a - BASE) >> 2]};
   endfunction

   task automatic load_word(input int idx, input logic [31:0] data);
      load_we   = 1'b1;
      load_addr = AW'(idx);
      load_data = data;
      step();
      load_we = 1'b0;
      ref_mem[idx] = data;
   endtask

   // rmode: 0 = rready always high, 1 = pattern 1,0,0,1,1,1, 2 = random
   task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [ID_W-1:0] id, input int rmode);
      bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int          b, cyc, waitc;
      bit          rr;
      logic [33:0] e;
      $display("read  addr=%h len=%0d burst=%0d id=%0d rmode=%0d", addr, len, burst, id, rmode);
      arvalid = 1'b1;
      araddr  = addr;
      arlen   = 8'(len);
      arburst = burst;
      arid    = id;
      #1;
      waitc = 0;
      while (!arready && waitc < 20) begin
         step();
         waitc++;
      end
      chk("arready", 32'(arready), 32'd1);
      chk("awready_blocked", 32'(awready), 32'd0);
      step();
      arvalid = 1'b0;
      b   = 0;
      cyc = 0;
      while (b <= len && cyc < 16 * (len + 1) + 16) begin
         case (rmode)
            0:       rr = 1;
            1:       rr = pat[cyc % 6];
            default: rr = ($urandom_range(0, 3) != 0);
         endcase
         rready = rr;
         e = exp_beat(addr, len, burst, b);
         chk($sformatf("rvalid b%0d", b), 32'(rvalid), 32'd1);
         chk($sformatf("rdata b%0d", b), rdata, e[31:0]);
         chk($sformatf("rresp b%0d", b), 32'(rresp), 32'(e[33:32]));
         chk($sformatf("rid b%0d", b), 32'(rid), 32'(id));
         chk($sformatf("rlast b%0d", b), 32'(rlast), 32'(b == len));
         chk("arready_busy", 32'(arready), 32'd0);
         step();
         if (rr) b++;
         cyc++;
      end
      rready = 1'b0;
      chk("burst_beats", 32'(b), 32'(len + 1));
      chk("rvalid_end", 32'(rvalid), 32'd0);
      chk("arready_end", 32'(arready), 32'd1);
   endtask

   task automatic do_write(input logic [ID_W-1:0] id, input int nbeats);
      int waitc;
      $display("write id=%0d beats=%0d", id, nbeats);
      awvalid = 1'b1;
      awid    = id;
      #1;
      waitc = 0;
      while (!awready && waitc < 20) begin
         step();
         waitc++;
      end
      chk("awready", 32'(awready), 32'd1);
      step();
      awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         wvalid = 1'b1;
         wlast  = (i == nbeats - 1);
         #1;
         chk("wready", 32'(wready), 32'd1);
         step();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      bready = 1'b0;
      chk("bvalid", 32'(bvalid), 32'd1);
      chk("bresp", 32'(bresp), 32'h2);
      chk("bid", 32'(bid), 32'(id));
      step();
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      bready = 1'b1;
      step();
      bready = 1'b0;
      chk("bvalid_done", 32'(bvalid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 0;
      awvalid = 0; awid = 0; wvalid = 0; wlast = 0; bready = 0;
      load_we = 0; load_addr = 0; load_data = 0;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rlast", 32'(rlast), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rresp", 32'(rresp), 32'd0);
      chk("rst_rid", 32'(rid), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_bresp", 32'(bresp), 32'd0);
      chk("rst_bid", 32'(bid), 32'd0);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_awready", 32'(awready), 32'd1);

      // Preload random contents, then the program words
      for (int i = 0; i < DEPTH; i++)
         load_word(i, $urandom);
      load_word(0, 32'h0000_0013);
      load_word(1, 32'h0010_0093);
      load_word(2, 32'h0020_0113);
      load_word(3, 32'h0030_0193);

      // Full-throughput and stalled bursts
      do_read(BASE, 3, 2'b01, 4'd5, 0);
      do_read(BASE, 3, 2'b01, 4'd5, 1);

      // Burst starting below the base: DECERR then word 0
      do_read(32'h7FFF_FFFC, 1, 2'b01, 4'd1, 0);

      // Simultaneous AR/AW: read first, then the write drains
      awvalid = 1'b1;
      awid    = 4'd9;
      do_read(BASE + 32'd4, 1, 2'b01, 4'd7, 0);
      do_write(4'd9, 2);

      // WRAP, FIXED, reserved burst type, top-of-array crossing, unsupported WRAP length
      do_read(BASE + 32'd8, 3, 2'b10, 4'd2, 0);
      do_read(BASE + 32'd12, 2, 2'b00, 4'd3, 0);
      do_read(BASE, 2, 2'b11, 4'd4, 0);
      do_read(BASE + 32'(4 * DEPTH - 8), 3, 2'b01, 4'd6, 2);
      do_read(BASE + 32'd20, 2, 2'b10, 4'd8, 0);

      // Load/read collision on the same word returns the old word
      $display("read  collide addr=%h with load", BASE);
      arvalid   = 1'b1; araddr = BASE; arlen = 8'd0; arburst = 2'b01; arid = 4'd3;
      load_we   = 1'b1; load_addr = '0; load_data = 32'hDEAD_BEEF;
      step();
      arvalid = 1'b0;
      load_we = 1'b0;
      chk("collide_rvalid", 32'(rvalid), 32'd1);
      chk("collide_rdata", rdata, ref_mem[0]);
      rready = 1'b1;
      step();
      rready = 1'b0;
      ref_mem[0] = 32'hDEAD_BEEF;
      do_read(BASE, 0, 2'b01, 4'd3, 0);

      // Reset during beat 1 of a 4-beat burst
      $display("read  reset mid-burst addr=%h", BASE);
      arvalid = 1'b1; araddr = BASE; arlen = 8'd3; arburst = 2'b01; arid = 4'd2;
      rready  = 1'b1;
      step();
      arvalid = 1'b0;
      step();
      chk("mid_rdata_b1", rdata, ref_mem[1]);
      rst = 1'b1;
      step();
      chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rst_arready", 32'(arready), 32'd1);
      rst    = 1'b0;
      rready = 1'b0;
      step();
      do_read(BASE, 3, 2'b01, 4'd2, 0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         int          len, kind;
         kind = int'($urandom_range(0, 3));
         case (kind)
            0:       a = BASE - 32'(4 * $urandom_range(0, 4));
            1:       a = BASE + 32'(4 * DEPTH) - 32'(4 * $urandom_range(0, 6));
            default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         endcase
         a[1:0] = 2'($urandom_range(0, 3));
         len = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : (1 << $urandom_range(1, 4)) - 1;
         if ($urandom_range(0, 5) == 0)
            do_write(4'($urandom), int'($urandom_range(1, 4)));
         do_read(a, len, 2'($urandom_range(0, 3)), 4'($urandom), 2);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
